gate_seq_mac: RTL and testbench
===============================

# gate_seq_mac

Sequential fixed-point gate engine for the LSTM layer. It computes, for every hidden row j, `gateOutput[j] = bias[j] + Σk Wx[j][k]·x[k] + Σk Wh[j][k]·h[k]`. All HIDDEN_SZ rows accumulate in parallel, one weight column per cycle, with X columns first and then H columns. The result is held behind a valid/ack handshake until the cell-state unit consumes it.

## Interface
- INPUT_SZ, 8: length of input vector x (≥2).
- HIDDEN_SZ, 64: number of hidden rows, and length of h (≥2).
- QN, 6: integer bits (excluding sign).
- QM, 11: fractional bits.
- Derived values:
  - BITWIDTH = QN+QM+1.
  - LAYER_BITWIDTH = BITWIDTH·HIDDEN_SZ.
  - ADDR_X = clog2(INPUT_SZ).
  - ADDR_Y = clog2(HIDDEN_SZ).
  - ACC_W = 2·BITWIDTH + clog2(INPUT_SZ+HIDDEN_SZ+1) + 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a computation; sampled only in IDLE.
- outAck  in  1  consumer has taken gateOutput.
- inputVec  in  BITWIDTH  x[colAddress_X], signed Q(QN.QM), valid one cycle after the address is issued.
- prevLayerOut  in  BITWIDTH  h[colAddress_Y], with the same timing.
- weightCol_X  in  LAYER_BITWIDTH  column colAddress_X of Wx, row j at [j·BITWIDTH +: BITWIDTH], with the same timing.
- weightCol_Y  in  LAYER_BITWIDTH  column colAddress_Y of Wh, with the same timing.
- biasVec  in  LAYER_BITWIDTH  bias per row; must be stable from start to dataReady_gate.
- colAddress_X  out  ADDR_X  X column read address.
- colAddress_Y  out  ADDR_Y  H column read address.
- busy  out  1  high whenever state ≠ IDLE.
- dataReady_gate  out  1  gateOutput valid; held until acknowledged.
- gateOutput  out  LAYER_BITWIDTH  signed result per row.
- ovfFlag  out  1  some row exceeded the output range in the current result.

## Operation
- States: IDLE → LOAD → MAC_X → MAC_Y → FINAL → VALID → IDLE.
- **IDLE:** when start=1, go to LOAD. colAddress_X=0, colAddress_Y=0.
- **LOAD (1 cycle):**
  - Each accumulator is set to bias[j] sign-extended to ACC_W and shifted left by QM.
  - colAddress_X=0 is driven.
- **MAC_X (INPUT_SZ cycles, counter i=0..INPUT_SZ-1):**
  - Each cycle: acc[j] += Wx[j][i]·x[i], a full-precision signed product.
  - Address driven: X address i+1; on the last cycle, colAddress_Y=0 instead.
- **MAC_Y (HIDDEN_SZ cycles, counter k):**
  - Each cycle: acc[j] += Wh[j][k]·h[k].
  - Address driven: colAddress_Y=k+1; nothing on the last cycle.
- **FINAL (1 cycle):**
  - r[j] = acc[j] >>> QM (arithmetic shift, floor).
  - r[j] is narrowed to BITWIDTH and registered into gateOutput.
  - ovfFlag is registered in the same cycle.
- **VALID:**
  - dataReady_gate=1; gateOutput and ovfFlag are held stable.
  - When outAck=1, go to IDLE on the next edge.
- Address outputs are registered. colAddress_X holds its last value outside MAC_X; colAddress_Y holds its last value outside MAC_Y.
- start while busy=1 is ignored; no queueing.
- outAck outside VALID is ignored.
- The accumulator never overflows for any input values, given the ACC_W sizing.

## Timing
- Reset value of every output is 0. State returns to IDLE. Accumulators are cleared.
- Reset asserted mid-operation aborts the computation at the next edge; no partial result is emitted.
- Latency: start sampled at edge E0 gives dataReady_gate=1 after edge E0+INPUT_SZ+HIDDEN_SZ+2 (74 cycles at the defaults).
- Throughput: the minimum start-to-start interval is INPUT_SZ+HIDDEN_SZ+3 cycles, when outAck is held at 1.
- Once VALID is reached, gateOutput changes only after reset or after the next FINAL.
- Memory contract: data for an address issued at edge t must be valid before edge t+1.

## Configuration
- **GATE_SAT_EN defined:**
  - Out-of-range r[j] clamps to 2^(BITWIDTH-1)-1 or -2^(BITWIDTH-1).
  - ovfFlag=1 if any row clamped.
- **GATE_SAT_EN undefined:**
  - gateOutput[j] = r[j][BITWIDTH-1:0] (wrap).
  - ovfFlag is tied to 0.

## Test plan
Values use the defaults; 1.0 = 2048.
- **Reset:** assert reset for 2 cycles with random inputs → all outputs 0; busy=0; addresses 0.
- **Basic sum:** Wx all 2048, x all 2048, Wh all 0, bias all 1024, start → dataReady_gate after 74 cycles; every row = 17408 (8.5); ovfFlag=0.
- **Floor rounding:** Wx[0][0]=-1, x[0]=1, everything else 0, bias 0 → row0 = -1 (0x3FFFF); other rows 0.
- **Overflow:** Wx, Wh, x, h all 131071:
  - With GATE_SAT_EN: every row = 131071 and ovfFlag=1.
  - Without GATE_SAT_EN: every row equals the low 18 bits of the floor-shifted exact sum, and ovfFlag=0.
- **Handshake:** hold outAck=0 for 10 cycles after valid → gateOutput is stable and the start pulses issued meanwhile are ignored. Then outAck=1 → busy=0 on the next cycle. A new start then completes 74 cycles later.
- **Abort:** pulse reset during MAC_Y (cycle 40) → IDLE next cycle with outputs 0. A following start with the basic-sum data gives 17408.

Source files
------------

// File: rtl/gate_seq_mac.sv
// LSTM gate engine: per-row bias + Wx*x + Wh*h, one weight column per cycle.
// Optional output saturation with overflow flag when GATE_SAT_EN is defined.
module gate_seq_mac_lane #(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11,
  parameter int ACC_W    = 44
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_mac,
  input  logic [BITWIDTH-1:0] i_bias,
  input  logic [BITWIDTH-1:0] i_w,
  input  logic [BITWIDTH-1:0] i_v,
  output logic [BITWIDTH-1:0] o_res,
  output logic                o_ovf
);
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [2*BITWIDTH-1:0] w_prod;

  assign w_prod = $signed(i_w) * $signed(i_v);

  always_ff @(posedge clock) begin
    if (reset)       r_acc <= '0;
    else if (i_load) r_acc <= {{(ACC_W-BITWIDTH-QM){i_bias[BITWIDTH-1]}}, i_bias, {QM{1'b0}}};
    else if (i_mac)  r_acc <= r_acc + {{(ACC_W-2*BITWIDTH){w_prod[2*BITWIDTH-1]}}, w_prod};
  end

`ifdef GATE_SAT_EN
  // In range only when every bit above the result sign matches it.
  logic [ACC_W-QM-BITWIDTH:0] w_hi;
  logic                       w_ovr;
  assign w_hi  = r_acc[ACC_W-1:QM+BITWIDTH-1];
  assign w_ovr = !((&w_hi) || !(|w_hi));
  assign o_res = !w_ovr ? r_acc[QM+BITWIDTH-1:QM] :
                 r_acc[ACC_W-1] ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
  assign o_ovf = w_ovr;
`else
  assign o_res = r_acc[QM+BITWIDTH-1:QM];
  assign o_ovf = 1'b0;
`endif
endmodule

module gate_seq_mac #(
  parameter int INPUT_SZ  = 8,
  parameter int HIDDEN_SZ = 64,
  parameter int QN        = 6,
  parameter int QM        = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int ADDR_X         = $clog2(INPUT_SZ),
  localparam int ADDR_Y         = $clog2(HIDDEN_SZ),
  localparam int ACC_W          = 2*BITWIDTH + $clog2(INPUT_SZ+HIDDEN_SZ+1) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      outAck,
  input  logic [BITWIDTH-1:0]       inputVec,
  input  logic [BITWIDTH-1:0]       prevLayerOut,
  input  logic [LAYER_BITWIDTH-1:0] weightCol_X,
  input  logic [LAYER_BITWIDTH-1:0] weightCol_Y,
  input  logic [LAYER_BITWIDTH-1:0] biasVec,
  output logic [ADDR_X-1:0]         colAddress_X,
  output logic [ADDR_Y-1:0]         colAddress_Y,
  output logic                      busy,
  output logic                      dataReady_gate,
  output logic [LAYER_BITWIDTH-1:0] gateOutput,
  output logic                      ovfFlag
);
  localparam int CNT_W = (ADDR_X > ADDR_Y) ? ADDR_X : ADDR_Y;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MAC_X = 3'd2;
  localparam logic [2:0] MAC_Y = 3'd3;
  localparam logic [2:0] FINAL = 3'd4;
  localparam logic [2:0] VALID = 3'd5;

  logic [2:0]                r_st;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_X-1:0]         r_addr_x;
  logic [ADDR_Y-1:0]         r_addr_y;
  logic [LAYER_BITWIDTH-1:0] r_gate;
  logic                      r_ovf;

  logic [CNT_W-1:0]                   w_cnt_nx;
  logic                               w_sel_y;
  logic [HIDDEN_SZ-1:0][BITWIDTH-1:0] w_res;
  logic [HIDDEN_SZ-1:0]               w_ovf;

  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_sel_y  = (r_st == MAC_Y);

  genvar j;
  generate
    for (j = 0; j < HIDDEN_SZ; j++) begin : g_lane
      gate_seq_mac_lane #(.BITWIDTH(BITWIDTH), .QM(QM), .ACC_W(ACC_W)) u_lane (
        .clock  (clock),
        .reset  (reset),
        .i_load (r_st == LOAD),
        .i_mac  ((r_st == MAC_X) || w_sel_y),
        .i_bias (biasVec[j*BITWIDTH +: BITWIDTH]),
        .i_w    (w_sel_y ? weightCol_Y[j*BITWIDTH +: BITWIDTH] : weightCol_X[j*BITWIDTH +: BITWIDTH]),
        .i_v    (w_sel_y ? prevLayerOut : inputVec),
        .o_res  (w_res[j]),
        .o_ovf  (w_ovf[j])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_addr_x <= '0;
      r_addr_y <= '0;
      r_gate   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_st)
        IDLE: begin
          r_addr_x <= '0;
          r_addr_y <= '0;
          if (start) r_st <= LOAD;
        end
        LOAD: begin
          r_addr_x <= '0;
          r_cnt    <= '0;
          r_st     <= MAC_X;
        end
        MAC_X: begin
          // Last X column: pre-issue H column 0 so MAC_Y starts without a bubble.
          if (r_cnt == CNT_W'(INPUT_SZ-1)) begin
            r_addr_y <= '0;
            r_cnt    <= '0;
            r_st     <= MAC_Y;
          end else begin
            r_addr_x <= w_cnt_nx[ADDR_X-1:0];
            r_cnt    <= w_cnt_nx;
          end
        end
        MAC_Y: begin
          if (r_cnt == CNT_W'(HIDDEN_SZ-1)) begin
            r_st <= FINAL;
          end else begin
            r_addr_y <= w_cnt_nx[ADDR_Y-1:0];
            r_cnt    <= w_cnt_nx;
          end
        end
        FINAL: begin
          r_gate <= w_res;
          r_ovf  <= |w_ovf;
          r_st   <= VALID;
        end
        VALID:   if (outAck) r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end

  assign colAddress_X   = r_addr_x;
  assign colAddress_Y   = r_addr_y;
  assign busy           = (r_st != IDLE);
  assign dataReady_gate = (r_st == VALID);
  assign gateOutput     = r_gate;
  assign ovfFlag        = r_ovf;
endmodule

// File: tb/tb_gate_seq_mac.sv
// Directed bench for gate_seq_mac: memory model, arithmetic scoreboard, handshake and abort.
module tb_gate_seq_mac;
  localparam int IN = 8, HID = 64, QN = 6, QM = 11;
  localparam int B = QN + QM + 1, L = B * HID;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, outAck = 1'b0;
  logic [B-1:0] inputVec, prevLayerOut;
  logic [L-1:0] weightCol_X, weightCol_Y, biasVec, gateOutput;
  logic [2:0]   colAddress_X;
  logic [5:0]   colAddress_Y;
  logic         busy, dataReady_gate, ovfFlag;

  logic signed [B-1:0] wx [HID][IN];
  logic signed [B-1:0] wh [HID][HID];
  logic signed [B-1:0] xv [IN];
  logic signed [B-1:0] hv [HID];
  logic signed [B-1:0] bs [HID];

  logic [L-1:0] exp_q [$];
  logic         exp_o_q [$];
  logic [L-1:0] saved;
  int n_chk = 0, n_err = 0;

  gate_seq_mac dut (
    .clock(clock), .reset(reset), .start(start), .outAck(outAck),
    .inputVec(inputVec), .prevLayerOut(prevLayerOut),
    .weightCol_X(weightCol_X), .weightCol_Y(weightCol_Y), .biasVec(biasVec),
    .colAddress_X(colAddress_X), .colAddress_Y(colAddress_Y),
    .busy(busy), .dataReady_gate(dataReady_gate),
    .gateOutput(gateOutput), .ovfFlag(ovfFlag)
  );

  always #5 clock = ~clock;

  // Column memories answer combinationally from the registered address.
  always_comb begin
    weightCol_X = '0;
    weightCol_Y = '0;
    biasVec     = '0;
    for (int j = 0; j < HID; j++) begin
      weightCol_X[j*B +: B] = wx[j][colAddress_X];
      weightCol_Y[j*B +: B] = wh[j][colAddress_Y];
      biasVec[j*B +: B]     = bs[j];
    end
  end
  assign inputVec     = xv[colAddress_X];
  assign prevLayerOut = hv[colAddress_Y];

  task automatic chk(input string tag, input int idx, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, expv);
    end
  endtask

  task automatic set_all(input int a, input int b, input int c, input int d, input int e);
    for (int j = 0; j < HID; j++) begin
      for (int k = 0; k < IN; k++)  wx[j][k] = B'(a);
      for (int k = 0; k < HID; k++) wh[j][k] = B'(c);
      bs[j] = B'(e);
    end
    for (int k = 0; k < IN; k++)  xv[k] = B'(b);
    for (int k = 0; k < HID; k++) hv[k] = B'(d);
  endtask

  task automatic set_rand();
    for (int j = 0; j < HID; j++) begin
      for (int k = 0; k < IN; k++)  wx[j][k] = B'($urandom);
      for (int k = 0; k < HID; k++) wh[j][k] = B'($urandom);
      bs[j] = B'($urandom);
    end
    for (int k = 0; k < IN; k++)  xv[k] = B'($urandom);
    for (int k = 0; k < HID; k++) hv[k] = B'($urandom);
  endtask

  task automatic push_exp();
    logic [L-1:0] v;
    logic o;
    longint s, r;
    v = '0;
    o = 1'b0;
    for (int j = 0; j < HID; j++) begin
      s = longint'(bs[j]) * 2048;
      for (int k = 0; k < IN; k++)  s += longint'(wx[j][k]) * longint'(xv[k]);
      for (int k = 0; k < HID; k++) s += longint'(wh[j][k]) * longint'(hv[k]);
      r = s >>> QM;
`ifdef GATE_SAT_EN
      if (r > 131071) begin r = 131071; o = 1'b1; end
      else if (r < -131072) begin r = -131072; o = 1'b1; end
`endif
      v[j*B +: B] = r[B-1:0];
    end
    exp_q.push_back(v);
    exp_o_q.push_back(o);
  endtask

  task automatic run_job(input string tag);
    int cyc;
    logic [L-1:0] ev;
    logic eo;
    push_exp();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 0;
    while (!dataReady_gate && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_latency"}, 0, cyc, 74);
    ev = exp_q.pop_front();
    eo = exp_o_q.pop_front();
    for (int j = 0; j < HID; j++)
      chk(tag, j, longint'(gateOutput[j*B +: B]), longint'(ev[j*B +: B]));
    chk({tag, "_ovf"}, 0, longint'(ovfFlag), longint'(eo));
  endtask

  task automatic do_ack(input string tag);
    outAck = 1'b1;
    @(negedge clock) outAck = 1'b0;
    chk({tag, "_ack_busy"}, 0, longint'(busy), 0);
    chk({tag, "_ack_rdy"}, 0, longint'(dataReady_gate), 0);
  endtask

  initial begin
    // Reset with random stimulus on every input
    set_rand();
    repeat (2) begin
      start  = 1'($urandom);
      outAck = 1'($urandom);
      @(negedge clock);
    end
    chk("rst_busy", 0, longint'(busy), 0);
    chk("rst_rdy", 0, longint'(dataReady_gate), 0);
    chk("rst_ovf", 0, longint'(ovfFlag), 0);
    chk("rst_ax", 0, longint'(colAddress_X), 0);
    chk("rst_ay", 0, longint'(colAddress_Y), 0);
    chk("rst_gate_nz", 0, longint'(|gateOutput), 0);
    start = 1'b0; outAck = 1'b0; reset = 1'b0;
    @(negedge clock);

    // Basic sum: 8 * 1.0 * 1.0 + 0.5
    set_all(2048, 2048, 0, 0, 1024);
    run_job("basic");
    chk("basic_const", 0, longint'(gateOutput[B-1:0]), 17408);
    do_ack("basic");

    // Floor rounding of a tiny negative product
    set_all(0, 0, 0, 0, 0);
    wx[0][0] = -1;
    xv[0]    = 1;
    run_job("floor");
    chk("floor_const", 0, longint'(gateOutput[B-1:0]), 'h3FFFF);
    do_ack("floor");

    set_all(131071, 131071, 131071, 131071, 0);
    run_job("ovf");
    do_ack("ovf");

    set_rand();
    run_job("rand");
    do_ack("rand");

    // Handshake: hold off the ack, spray ignored starts
    set_all(0, 0, 0, 0, 0);
    wx[0][0] = -1;
    xv[0]    = 1;
    run_job("hold");
    saved = gateOutput;
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(negedge clock);
      chk("hold_stable", i, longint'(gateOutput === saved), 1);
      chk("hold_rdy", i, longint'(dataReady_gate), 1);
    end
    start = 1'b0;
    do_ack("hold");
    repeat (5) @(negedge clock);
    chk("hold_noqueue", 0, longint'(busy), 0);
    set_rand();
    run_job("after_hold");
    do_ack("after_hold");

    // Abort mid MAC_Y; previous result must be cleared, nothing emitted
    set_all(0, 0, 0, 0, 0);
    wx[0][0] = -1;
    xv[0]    = 1;
    run_job("pre_abort");
    do_ack("pre_abort");
    set_all(2048, 2048, 0, 0, 1024);
    push_exp();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_busy_pre", 0, longint'(busy), 1);
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_o_q.pop_back());
    chk("abort_busy", 0, longint'(busy), 0);
    chk("abort_rdy", 0, longint'(dataReady_gate), 0);
    chk("abort_gate_nz", 0, longint'(|gateOutput), 0);
    chk("abort_ovf", 0, longint'(ovfFlag), 0);
    chk("abort_ay", 0, longint'(colAddress_Y), 0);
    repeat (80) @(negedge clock);
    chk("abort_no_result", 0, longint'(dataReady_gate), 0);
    run_job("post_abort");
    chk("post_abort_const", 0, longint'(gateOutput[B-1:0]), 17408);
    do_ack("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
